// File: rtl/rom_pkg.sv
// Shared constants, word type and fixed contents for the 16-word program ROM.
package rom_pkg;
  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 16;
  localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

  typedef logic [ROM_DATA_W-1:0] rom_word_t;

  localparam rom_word_t ROM_CONTENT [ROM_DEPTH] = '{
    16'h1A05, 16'h2B03, 16'h3C0F, 16'h4D10,
    16'h5E22, 16'h6F01, 16'h7000, 16'h8123,
    16'h9456, 16'hA789, 16'hBABC, 16'hCDEF,
    16'hD0F0, 16'hE00F, 16'hF0FF, 16'hFFFF
  };
endpackage

// File: rtl/rom_parity.sv
// Even-parity generator: XOR reduction of one word, purely combinational, no flow control.
module rom_parity
  import rom_pkg::*;
#(
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);
  assign parity_o = ^data_i;
endmodule

// File: rtl/rom.sv
// Fixed 16x16 ROM: combinational data_out plus a one-cycle registered read (data_q/valid_q), no stalls.
// Optional registered parity output parity_q when ROM_PARITY_EN is defined.
module rom
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q
`ifdef ROM_PARITY_EN
  ,
  output logic              parity_q
`endif
);
  rom_word_t         rom_word;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;

  // The lookup is independent of clk and rst so the PC-driven fetch path sees no latency.
  assign rom_word = ROM_CONTENT[address];
  assign data_out = rom_word;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (rd_en) begin
      data_d  = rom_word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef ROM_PARITY_EN
  logic word_parity;
  logic parity_d;

  rom_parity #(.DATA_W(DATA_W)) u_parity (
    .data_i   (rom_word),
    .parity_o (word_parity)
  );

  always_comb begin
    parity_d = parity_q;
    if (rd_en) begin
      parity_d = word_parity;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif
endmodule

// File: tb/tb_rom.sv
// Self-checking bench for rom: directed scenarios plus a randomized run against a table-driven model.
module tb_rom;
  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [3:0]  address = 4'd0;
  logic [15:0] data_out;
  logic [15:0] data_q;
  logic        valid_q;
`ifdef ROM_PARITY_EN
  logic        parity_q;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] golden [16] = '{
    16'h1A05, 16'h2B03, 16'h3C0F, 16'h4D10, 16'h5E22, 16'h6F01, 16'h7000, 16'h8123,
    16'h9456, 16'hA789, 16'hBABC, 16'hCDEF, 16'hD0F0, 16'hE00F, 16'hF0FF, 16'hFFFF
  };

  logic [15:0] exp_data  = 16'h0000;
  logic        exp_valid = 1'b0;
  logic        exp_par   = 1'b0;

  rom dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .rd_en    (rd_en),
    .data_out (data_out),
    .data_q   (data_q),
    .valid_q  (valid_q)
`ifdef ROM_PARITY_EN
    ,
    .parity_q (parity_q)
`endif
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic ones_odd(input logic [15:0] w);
    int n = 0;
    for (int i = 0; i < 16; i++) if (w[i]) n++;
    return (n % 2) == 1;
  endfunction

  // Advance one rising edge with the current inputs and update the reference model.
  task automatic tick();
    if (rst) begin
      exp_data = 16'h0000; exp_valid = 1'b0; exp_par = 1'b0;
    end else if (rd_en) begin
      exp_data = golden[address]; exp_valid = 1'b1; exp_par = ones_odd(golden[address]);
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [15:0] sweep_exp [5];
    sweep_exp = '{16'h1A05, 16'h2B03, 16'h3C0F, 16'h4D10, 16'h5E22};
    for (int a = 0; a < 5; a++) begin
      address = 4'(a);
      #10;
      checks++;
      if (data_out !== sweep_exp[a]) begin
        errors++;
        $display("FAIL sweep addr=%0d data_out=%h expected=%h", a, data_out, sweep_exp[a]);
      end
    end
  endtask

  task automatic test_reset();
    clk_run = 1'b1;
    rst = 1'b1; rd_en = 1'b1; address = 4'd5;
    tick(); tick();
    checks++;
    if (data_q !== 16'h0000) begin errors++; $display("FAIL reset_data data_q=%h expected=0000", data_q); end
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid valid_q=%b expected=0", valid_q); end
    checks++;
    if (data_out !== 16'h6F01) begin errors++; $display("FAIL reset_comb data_out=%h expected=6F01", data_out); end
`ifdef ROM_PARITY_EN
    checks++;
    if (parity_q !== 1'b0) begin errors++; $display("FAIL reset_parity parity_q=%b expected=0", parity_q); end
`endif
  endtask

  task automatic test_read_max();
    rst = 1'b0; rd_en = 1'b1; address = 4'd15;
    tick();
    checks++;
    if (data_q !== 16'hFFFF) begin errors++; $display("FAIL max_data data_q=%h expected=FFFF", data_q); end
    checks++;
    if (valid_q !== 1'b1) begin errors++; $display("FAIL max_valid valid_q=%b expected=1", valid_q); end
`ifdef ROM_PARITY_EN
    checks++;
    if (parity_q !== 1'b0) begin errors++; $display("FAIL max_parity parity_q=%b expected=0", parity_q); end
`endif
  endtask

  task automatic test_hold();
    rd_en = 1'b1; address = 4'd0;
    tick();
    rd_en = 1'b0; address = 4'd1;
    tick();
    checks++;
    if (data_q !== 16'h1A05) begin errors++; $display("FAIL hold_data data_q=%h expected=1A05", data_q); end
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL hold_valid valid_q=%b expected=0", valid_q); end
    checks++;
    if (data_out !== 16'h2B03) begin errors++; $display("FAIL hold_comb data_out=%h expected=2B03", data_out); end
`ifdef ROM_PARITY_EN
    checks++;
    if (parity_q !== 1'b1) begin errors++; $display("FAIL hold_parity parity_q=%b expected=1", parity_q); end
`endif
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      tick();
      checks++;
      if (data_q !== golden[a] || valid_q !== 1'b1) begin
        errors++;
        $display("FAIL b2b addr=%0d data_q=%h valid_q=%b expected=%h/1", a, data_q, valid_q, golden[a]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rd_en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 4'(a);
      tick();
    end
    address = 4'd8; rst = 1'b1;
    tick();
    checks++;
    if (data_q !== 16'h0000 || valid_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset data_q=%h valid_q=%b expected=0000/0", data_q, valid_q);
    end
    rst = 1'b0; address = 4'd9;
    tick();
    checks++;
    if (data_q !== 16'hA789 || valid_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_release data_q=%h valid_q=%b expected=A789/1", data_q, valid_q);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; rd_en = 1'b0;
    tick();
    for (int n = 0; n < 300; n++) begin
      rst     = ($urandom_range(0, 15) == 0);
      rd_en   = 1'($urandom_range(0, 1));
      address = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (data_out !== golden[address]) begin
        errors++;
        $display("FAIL rand_comb n=%0d addr=%0d data_out=%h expected=%h", n, address, data_out, golden[address]);
      end
      tick();
      checks++;
      if (data_q !== exp_data || valid_q !== exp_valid) begin
        errors++;
        $display("FAIL rand_reg n=%0d data_q=%h valid_q=%b expected=%h/%b", n, data_q, valid_q, exp_data, exp_valid);
      end
`ifdef ROM_PARITY_EN
      checks++;
      if (parity_q !== exp_par) begin
        errors++;
        $display("FAIL rand_parity n=%0d parity_q=%b expected=%b", n, parity_q, exp_par);
      end
`endif
    end
  endtask

  initial begin
    test_comb_sweep();
    test_reset();
    test_read_max();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom.md
ROM -- requirements
Module: rom

Interface
REQ-001 Parameter ADDR_W, default 4, address width in bits; only 4 is supported.
REQ-002 Parameter DATA_W, default 16, word width in bits; only 16 is supported.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 address  input  ADDR_W  read address (program-counter value).
REQ-006 data_out  output  DATA_W  combinational word at address.
REQ-007 rd_en  input  1  registered-read request.
REQ-008 data_q  output  DATA_W  registered read word.
REQ-009 valid_q  output  1  data_q holds a word loaded on the previous edge.
REQ-010 parity_q  output  1  even-parity bit of data_q; present only with ROM_PARITY_EN.

Function
REQ-011 Contents SHALL be fixed, 16 words, hex, addr 0..15: 1A05 2B03 3C0F 4D10 5E22 6F01 7000 8123 9456 A789 BABC CDEF D0F0 E00F F0FF FFFF.
REQ-012 data_out SHALL equal ROM[address] combinationally, zero cycles, independent of clk and rst.
REQ-013 data_out SHALL settle within the same delta-cycle sequence as an address change; no X for any 4-bit known address.
REQ-014 On a rising edge with rd_en=1 and rst=0, data_q SHALL load ROM[address] and valid_q SHALL be 1 (latency one cycle).
REQ-015 On a rising edge with rd_en=0 and rst=0, data_q SHALL hold and valid_q SHALL be 0.
REQ-016 Address 15 SHALL be a normal word; no wrap or out-of-range handling, since all 16 codes are valid.
REQ-017 Back-to-back rd_en cycles SHALL each load the address present at that edge; no stalls.
REQ-018 ROM contents SHALL NOT be writable at runtime.

Reset
REQ-019 With rst=1 on a rising edge: data_q=16'h0000, valid_q=0, parity_q=0; rd_en is ignored.
REQ-020 Reset SHALL NOT affect data_out.
REQ-021 Reset asserted mid-stream SHALL take priority; the first load after deassertion SHALL occur on the next edge with rd_en=1.

Configuration
REQ-022 Macro ROM_PARITY_EN defined: parity_q SHALL be registered with data_q and equal the XOR of all bits of the loaded word; it SHALL hold when rd_en=0 and be 0 on reset.
REQ-023 Macro ROM_PARITY_EN undefined: port parity_q and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-024 Package rom_pkg SHALL hold ADDR_W/DATA_W constants, a rom_word_t typedef and the 16-entry content constant array.
REQ-025 The parity function SHALL live in sub-module rom_parity (DATA_W-bit input, 1-bit XOR output), instantiated only under ROM_PARITY_EN.

Verification
REQ-026 Sweep address 0,1,2,3,4 at 10 ns steps, no clock edges -> data_out = 1A05, 2B03, 3C0F, 4D10, 5E22.
REQ-027 rst=1 for two edges with rd_en=1, address=5 -> data_q=0000, valid_q=0, data_out=6F01.
REQ-028 rst=0, rd_en=1, address=15, one edge -> data_q=FFFF, valid_q=1; parity_q=0 with ROM_PARITY_EN.
REQ-029 rd_en=1 at address 0, then rd_en=0 and address changed to 1 -> data_q stays 1A05, valid_q drops to 0, data_out=2B03; parity_q=1 with ROM_PARITY_EN.
REQ-030 Consecutive rd_en over addresses 0..15 -> data_q follows REQ-011 one cycle late, valid_q continuously 1.
REQ-031 rst raised during streaming at address 8 -> next edge data_q=0000, valid_q=0; after release, a read of address 9 gives A789.
